// File: rtl/sll_stream_reader_if.sv
// sll_stream_reader_if: bundles the linked-list op bus and the output stream of the
// list traversal engine.
//   master modport: the reader (drives ll_op/ll_addr/ll_data_in/ll_op_start and the
//                   m_* stream, receives list responses/status and m_ready).
//   slave modport:  the list plus the stream consumer.
// Parameters must match the sll_stream_reader instance they connect to.
interface sll_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_NODE   = 8
);
    localparam int unsigned ADDR_WIDTH = $clog2(MAX_NODE + 1);

    // List op bus
    logic [2:0]            ll_op;
    logic [ADDR_WIDTH-1:0] ll_addr;
    logic [DATA_WIDTH-1:0] ll_data_in;
    logic                  ll_op_start;
    logic                  ll_op_done;
    logic [DATA_WIDTH-1:0] ll_data_out;
    logic [ADDR_WIDTH-1:0] ll_next_node_addr;
    logic                  ll_fault;
    logic [ADDR_WIDTH-1:0] ll_head;
    logic [ADDR_WIDTH-1:0] ll_length;
    logic                  ll_empty;

    // Output stream
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_last;

    modport master (
        output ll_op, ll_addr, ll_data_in, ll_op_start,
        input  ll_op_done, ll_data_out, ll_next_node_addr, ll_fault,
        input  ll_head, ll_length, ll_empty,
        output m_valid, m_data, m_addr, m_last,
        input  m_ready
    );

    modport slave (
        input  ll_op, ll_addr, ll_data_in, ll_op_start,
        output ll_op_done, ll_data_out, ll_next_node_addr, ll_fault,
        output ll_head, ll_length, ll_empty,
        input  m_valid, m_data, m_addr, m_last,
        output m_ready
    );
endinterface

// File: rtl/sll_stream_reader.sv
// sll_stream_reader: walks a singly linked list from head to tail with Read_Addr ops and
// streams every node (data, address, last flag) out on a valid/ready port.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        traversal request, accepted only when idle
//   busy         traversal in progress
//   done         one-cycle pulse at the end of a traversal (normal or error)
//   err          sticky fault / illegal next pointer, cleared by an accepted start
//   count        nodes handed off in the current or last traversal
//   bus          sll_stream_reader_if.master: ll_* list op bus and m_* output stream
// Optional feature: define SLL_READER_PREFETCH_EN to overlap the next node read with
// the current output beat (one-entry prefetch buffer, 2 cycles/node).
module sll_stream_reader #(
    parameter int unsigned  DATA_WIDTH = 8,
    parameter int unsigned  MAX_NODE   = 8,
    localparam int unsigned ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] count,
    sll_stream_reader_if.master   bus
);
    localparam logic [ADDR_WIDTH-1:0] AddrNull = ADDR_WIDTH'(MAX_NODE + 1);
    localparam logic [ADDR_WIDTH-1:0] AddrMax  = ADDR_WIDTH'(MAX_NODE);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;
    localparam logic [1:0] StFin  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  op_start_q, op_start_d;
    logic [ADDR_WIDTH-1:0] ll_addr_q, ll_addr_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] next_q, next_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] cnt_inc;

    assign cnt_inc = count_q + ADDR_WIDTH'(1);

`ifdef SLL_READER_PREFETCH_EN
    logic                  pf_valid_q, pf_valid_d;
    logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d;
    logic [ADDR_WIDTH-1:0] pf_next_q, pf_next_d;
    logic                  pf_fault_q, pf_fault_d;
    logic                  pf_ret;
    logic                  pf_f;
    logic [DATA_WIDTH-1:0] pf_d;
    logic [ADDR_WIDTH-1:0] pf_n;
    logic [ADDR_WIDTH-1:0] cnt_inc2;

    // A read issued during OUT is a prefetch; it returns while the beat may still be pending.
    assign pf_ret   = (state_q == StOut) && op_start_q && bus.ll_op_done;
    assign cnt_inc2 = count_q + ADDR_WIDTH'(2);
    assign pf_f     = pf_valid_q ? pf_fault_q : bus.ll_fault;
    assign pf_d     = pf_valid_q ? pf_data_q  : bus.ll_data_out;
    assign pf_n     = pf_valid_q ? pf_next_q  : bus.ll_next_node_addr;
`endif

    always_comb begin
        state_d    = state_q;
        op_start_d = op_start_q;
        ll_addr_d  = ll_addr_q;
        m_addr_d   = m_addr_q;
        data_d     = data_q;
        next_d     = next_q;
        last_d     = last_q;
        count_d    = count_q;
        len_d      = len_q;
        err_d      = err_q;
`ifdef SLL_READER_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_data_d  = pf_data_q;
        pf_next_d  = pf_next_q;
        pf_fault_d = pf_fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d     = bus.ll_length;
                    ll_addr_d = bus.ll_head;
                    count_d   = '0;
                    err_d     = 1'b0;
                    if (bus.ll_empty || bus.ll_length == '0) begin
                        state_d = StFin;
                    end else begin
                        op_start_d = 1'b1;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.ll_op_done) begin
                    op_start_d = 1'b0;
                    if (bus.ll_fault) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        data_d   = bus.ll_data_out;
                        m_addr_d = ll_addr_q;
                        next_d   = bus.ll_next_node_addr;
                        // Length snapshot wins: a stale tail pointer need not be NULL.
                        last_d   = (cnt_inc == len_q) || (bus.ll_next_node_addr == AddrNull);
                        state_d  = StOut;
`ifdef SLL_READER_PREFETCH_EN
                        if (!last_d && bus.ll_next_node_addr < AddrMax) begin
                            op_start_d = 1'b1;
                            ll_addr_d  = bus.ll_next_node_addr;
                        end
`endif
                    end
                end
            end
            StOut: begin
`ifdef SLL_READER_PREFETCH_EN
                if (pf_ret) begin
                    op_start_d = 1'b0;
                    pf_valid_d = 1'b1;
                    pf_data_d  = bus.ll_data_out;
                    pf_next_d  = bus.ll_next_node_addr;
                    pf_fault_d = bus.ll_fault;
                end
`endif
                if (bus.m_ready) begin
                    count_d = cnt_inc;
                    if (last_q) begin
                        state_d = StFin;
                    end else if (next_q >= AddrMax) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
`ifdef SLL_READER_PREFETCH_EN
                        if (pf_valid_q || pf_ret) begin
                            pf_valid_d = 1'b0;
                            if (pf_f) begin
                                err_d   = 1'b1;
                                state_d = StFin;
                            end else begin
                                data_d   = pf_d;
                                m_addr_d = ll_addr_q;
                                next_d   = pf_n;
                                last_d   = (cnt_inc2 == len_q) || (pf_n == AddrNull);
                                if (!last_d && pf_n < AddrMax) begin
                                    op_start_d = 1'b1;
                                    ll_addr_d  = pf_n;
                                end
                            end
                        end else begin
                            // Prefetch still outstanding: wait for it in REQ.
                            state_d = StReq;
                        end
`else
                        ll_addr_d  = next_q;
                        op_start_d = 1'b1;
                        state_d    = StReq;
`endif
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_start_q <= 1'b0;
            ll_addr_q  <= AddrNull;
            m_addr_q   <= '0;
            data_q     <= '0;
            next_q     <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
`ifdef SLL_READER_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_data_q  <= '0;
            pf_next_q  <= '0;
            pf_fault_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_start_q <= op_start_d;
            ll_addr_q  <= ll_addr_d;
            m_addr_q   <= m_addr_d;
            data_q     <= data_d;
            next_q     <= next_d;
            last_q     <= last_d;
            count_q    <= count_d;
            len_q      <= len_d;
            err_q      <= err_d;
`ifdef SLL_READER_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_data_q  <= pf_data_d;
            pf_next_q  <= pf_next_d;
            pf_fault_q <= pf_fault_d;
`endif
        end
    end

    assign busy            = (state_q == StReq) || (state_q == StOut);
    assign done            = (state_q == StFin);
    assign err             = err_q;
    assign count           = count_q;
    assign bus.ll_op       = 3'd0;
    assign bus.ll_addr     = ll_addr_q;
    assign bus.ll_data_in  = '0;
    assign bus.ll_op_start = op_start_q;
    assign bus.m_valid     = (state_q == StOut);
    assign bus.m_data      = data_q;
    assign bus.m_addr      = m_addr_q;
    assign bus.m_last      = (state_q == StOut) && last_q;
endmodule

// File: tb/tb_sll_stream_reader.sv
// tb_sll_stream_reader: self-checking bench for sll_stream_reader. A behavioural list
// responder serves Read_Addr ops from arrays; a sequential walk of those arrays gives the
// expected beat sequence, error flag and read count for each traversal.
module tb_sll_stream_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned MN = 8;
    localparam int unsigned AW = 4;
    localparam int          NULLA = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] count;

    sll_stream_reader_if #(.DATA_WIDTH(DW), .MAX_NODE(MN)) bus ();

    sll_stream_reader #(.DATA_WIDTH(DW), .MAX_NODE(MN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .count (count),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // List contents seen by the responder
    logic [7:0] mem_data [16];
    logic [3:0] mem_next [16];
    int         fault_at = -1;
    int         read_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ll_op_done        <= 1'b0;
            bus.ll_data_out       <= '0;
            bus.ll_next_node_addr <= '0;
            bus.ll_fault          <= 1'b0;
            read_idx              <= 0;
        end else begin
            if (start) read_idx <= 0;
            if (bus.ll_op_start && !bus.ll_op_done) begin
                bus.ll_op_done        <= 1'b1;
                bus.ll_data_out       <= mem_data[bus.ll_addr];
                bus.ll_next_node_addr <= mem_next[bus.ll_addr];
                bus.ll_fault          <= (read_idx == fault_at);
                read_idx              <= read_idx + 1;
            end else begin
                bus.ll_op_done <= 1'b0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            mem_data[i] = '0;
            mem_next[i] = 4'(NULLA);
        end
        fault_at = -1;
    endtask

    // rmode: 0 ready tied high, 1 random ready, 2 ready low 5 cycles on beat 2
    task automatic run_trav(input string name, input int rmode, input int exp_done_cyc);
        int  ed[$];
        int  ea[$];
        int  el[$];
        int  exp_err = 0;
        int  exp_reads = 0;
        int  n = 0;
        int  ptr, nx;
        bit  stop = 0;
        int  cyc = 0;
        int  beats = 0;
        int  reads = 0;
        int  first_v = -1;
        int  last_hs = -1;
        int  done_cyc = -1;
        int  hold = 0;
        bit  held = 0;
        logic [31:0] held_val = '0;

        // Reference walk
        if (!(bus.ll_empty || bus.ll_length == 0)) begin
            ptr = int'(bus.ll_head);
            for (int k = 0; k < 20 && !stop; k++) begin
                exp_reads++;
                if (exp_reads - 1 == fault_at) begin
                    exp_err = 1;
                    stop = 1;
                end else begin
                    ed.push_back(int'(mem_data[ptr]));
                    ea.push_back(ptr);
                    n++;
                    nx = int'(mem_next[ptr]);
                    if (n == int'(bus.ll_length) || nx == NULLA) begin
                        el.push_back(1);
                        stop = 1;
                    end else begin
                        el.push_back(0);
                        if (nx >= int'(MN)) begin
                            exp_err = 1;
                            stop = 1;
                        end
                        ptr = nx;
                    end
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        bus.m_ready = 1'b0;
        while (done_cyc < 0 && cyc < 600) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            case (rmode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = ($urandom % 3) != 0;
                default: begin
                    if (bus.m_valid && beats == 1 && hold < 5) begin
                        bus.m_ready = 1'b0;
                        hold++;
                    end else begin
                        bus.m_ready = 1'b1;
                    end
                end
            endcase
            #1;
            if (cyc == 1) begin
                check_eq({name, "_err_clr"}, 32'(err), 0);
                check_eq({name, "_cnt_clr"}, 32'(count), 0);
                check_eq({name, "_busy"}, 32'(busy), 32'(exp_reads > 0));
            end
            if (held) begin
                check_eq({name, "_hold"},
                         32'({bus.m_valid, bus.m_last, bus.m_addr, bus.m_data}), held_val);
            end
            if (bus.m_valid && first_v < 0) first_v = cyc;
            if (bus.ll_op_done) reads++;
            if (bus.m_valid && bus.m_ready) begin
                if (beats < ed.size()) begin
                    check_eq({name, "_beat"},
                             32'({bus.m_last, bus.m_addr, bus.m_data}),
                             32'({1'(el[beats]), 4'(ea[beats]), 8'(ed[beats])}));
                end else begin
                    check_eq({name, "_extra_beat"}, beats + 1, ed.size());
                end
                beats++;
                last_hs = cyc;
                held = 0;
            end else if (bus.m_valid) begin
                held = 1;
                held_val = 32'({bus.m_valid, bus.m_last, bus.m_addr, bus.m_data});
            end else begin
                held = 0;
            end
            if (done) done_cyc = cyc;
        end

        if (done_cyc < 0) begin
            check_eq({name, "_timeout"}, 32'(done), 1);
        end else begin
            check_eq({name, "_beats"}, beats, ed.size());
            check_eq({name, "_count"}, 32'(count), ed.size());
            check_eq({name, "_errflag"}, 32'(err), exp_err);
            check_eq({name, "_reads"}, reads, exp_reads);
            if (ed.size() > 0) check_eq({name, "_first_valid"}, first_v, 3);
            if (ed.size() > 0 && exp_reads == ed.size())
                check_eq({name, "_done_after_hs"}, done_cyc, last_hs + 1);
            if (exp_done_cyc > 0) check_eq({name, "_done_cyc"}, done_cyc, exp_done_cyc);
            @(negedge clk);
            #1;
            check_eq({name, "_idle"}, 32'({done, busy, bus.m_valid}), 0);
        end
    endtask

    task automatic build_abc();
        clear_mem();
        mem_data[0] = 8'h11; mem_next[0] = 4'd1;
        mem_data[1] = 8'h22; mem_next[1] = 4'd2;
        mem_data[2] = 8'h33; mem_next[2] = 4'(NULLA);
        bus.ll_head = 4'd0; bus.ll_length = 4'd3; bus.ll_empty = 1'b0;
    endtask

    task automatic build_random();
        int perm[8];
        int len, mode, j, t, k;
        clear_mem();
        for (int i = 0; i < 8; i++) perm[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        len = $urandom_range(1, 8);
        for (int i = 0; i < 8; i++) mem_data[i] = 8'($urandom);
        for (int i = 0; i < len - 1; i++) mem_next[perm[i]] = 4'(perm[i + 1]);
        bus.ll_head = 4'(perm[0]);
        bus.ll_length = 4'(len);
        bus.ll_empty = 1'b0;
        mode = $urandom_range(0, 4);
        case (mode)
            1: mem_next[perm[len - 1]] = 4'(perm[$urandom_range(0, len - 1)]);
            2: if (len < 8) bus.ll_length = 4'($urandom_range(len + 1, 8));
            3: begin
                k = $urandom_range(0, len - 1);
                mem_next[perm[k]] = ($urandom % 2) ? 4'd8 : 4'($urandom_range(10, 15));
                bus.ll_length = 4'd8;
            end
            4: if ($urandom % 2) begin
                bus.ll_empty = 1'b1;
                bus.ll_length = 4'd0;
                bus.ll_head = 4'(NULLA);
            end
            default: ;
        endcase
        if ($urandom % 4 == 0) fault_at = $urandom_range(0, len - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.m_ready = 1'b0;
        bus.ll_head = 4'(NULLA);
        bus.ll_length = 4'd0;
        bus.ll_empty = 1'b1;
        clear_mem();
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_outs",
                 32'({busy, done, err, count, bus.ll_op_start, bus.m_valid, bus.m_last}), 0);
        check_eq("reset_ll_addr", 32'(bus.ll_addr), NULLA);
        check_eq("reset_ll_op", 32'(bus.ll_op), 0);
        @(negedge clk);
        rst = 1'b0;

        // Empty list
        run_trav("empty", 0, 1);

        // push_back 0x11, 0x22, 0x33
`ifdef SLL_READER_PREFETCH_EN
        build_abc(); run_trav("abc", 0, 8);
`else
        build_abc(); run_trav("abc", 0, 10);
`endif

        // Node 1 deleted, 0x44 pushed to front in slot 1; node 2 keeps a stale next
        clear_mem();
        mem_data[1] = 8'h44; mem_next[1] = 4'd0;
        mem_data[0] = 8'h11; mem_next[0] = 4'd2;
        mem_data[2] = 8'h33; mem_next[2] = 4'd1;
        bus.ll_head = 4'd1; bus.ll_length = 4'd3; bus.ll_empty = 1'b0;
        run_trav("stale_tail", 0, -1);

        // Backpressure on beat 2
        build_abc(); run_trav("backpressure", 2, -1);

        // Fault on second read, then a clean traversal clears err
        build_abc(); fault_at = 1; run_trav("fault", 1, -1);
        build_abc(); run_trav("after_fault", 1, -1);

        // Reset while a read is pending
        build_abc();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        check_eq("rst_pre_req", 32'(bus.ll_op_start), 1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_drop", 32'({bus.ll_op_start, busy, bus.m_valid, done}), 0);
        check_eq("rst_ll_addr", 32'(bus.ll_addr), NULLA);
        @(negedge clk); rst = 1'b0;
        build_abc(); run_trav("after_rst", 0, -1);

        for (int it = 0; it < 40; it++) begin
            build_random();
            run_trav("rand", int'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sll_stream_reader.md
# sll_stream_reader

- Initiator-side traversal engine for the singly linked list storage block.
- On `start`, walks the list from head to tail by issuing Read_Addr ops (op=0) over the list's op_start/op_done interface.
- Streams each node's data and address out on a valid/ready port, with `last` marking the final node.
- Sits between the list instance and any consumer that needs an ordered dump, such as a scheduler or debug drain.

## Interface
- `DATA_WIDTH`, 8, node data width; must match the list instance.
- `MAX_NODE`, 8, list capacity; derived `ADDR_WIDTH = $clog2(MAX_NODE+1)`, `ADDR_NULL = MAX_NODE+1`.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle traversal request; ignored while `busy`.
- `busy`  out  1  traversal in progress.
- `done`  out  1  one-cycle pulse when a traversal ends (normally or on error).
- `err`  out  1  sticky until next accepted `start`; list fault or illegal next pointer.
- `count`  out  ADDR_WIDTH  nodes handed off on the stream in the current or last traversal.
- `ll_op`  out  3  always 3'd0 (Read_Addr).
- `ll_addr`  out  ADDR_WIDTH  node address being read.
- `ll_data_in`  out  DATA_WIDTH  tied 0.
- `ll_op_start`  out  1  op request; held until `ll_op_done` sampled.
- `ll_op_done`  in  1  op completion from list.
- `ll_data_out`  in  DATA_WIDTH  read data; valid while `ll_op_done`.
- `ll_next_node_addr`  in  ADDR_WIDTH  next pointer; valid while `ll_op_done`.
- `ll_fault`  in  1  list fault; qualified by `ll_op_done`.
- `ll_head`, `ll_length`  in  ADDR_WIDTH  list status.
- `ll_empty`  in  1  list status.
- `m_valid`  out  1  stream beat valid.
- `m_ready`  in  1  consumer accept.
- `m_data`  out  DATA_WIDTH  node data.
- `m_addr`  out  ADDR_WIDTH  node address.
- `m_last`  out  1  final node of traversal.

## Operation
- **States:** IDLE, REQ, OUT, FIN.
- **Reset values:** all outputs 0 except `ll_addr = ADDR_NULL`.
- **IDLE + `start`:**
  - Snapshot `len_snap = ll_length` and `ptr = ll_head`; clear `count` and `err`.
  - If `ll_empty` or `ll_length == 0`, go to FIN with no beats.
  - Otherwise assert `ll_op_start` with `ll_addr = ptr` and go to REQ.
- **REQ:** hold `ll_op_start` and `ll_addr` stable. On `ll_op_done`:
  - Drop `ll_op_start`.
  - If `ll_fault`, set `err` and go to FIN.
  - Otherwise capture data, `ptr`, and next pointer; set `m_last = (count+1 == len_snap) | (next == ADDR_NULL)`; go to OUT.
- **OUT:** assert `m_valid`; payload stable until `m_ready`. On handshake:
  - `count += 1`.
  - If `m_last`, go to FIN.
  - Else if `next >= MAX_NODE`, set `err` and go to FIN (non-NULL out-of-range pointer).
  - Else set `ptr = next` and issue the next read (REQ).
- **Termination:** `len_snap` is authoritative, because a stale tail pointer may not be NULL. A NULL next before `len_snap` is reached ends early with `m_last=1` and no error.
- **FIN:** pulse `done`, deassert `busy`, return to IDLE.
- **Interface rule:** `ll_op_start` is never asserted when `ll_op_done` was sampled high on the same edge unless `ll_addr` has advanced, so the list never re-executes a stale read.
- **List mutation:** the list must not be modified while `busy`. Integrity is not checked beyond the pointer range check.

## Timing
- `start` sampled at edge 0.
- `ll_op_start` high from cycle 1.
- List returns `ll_op_done` in cycle 2.
- `m_valid` from cycle 3.
- Base throughput: 3 cycles/node with `m_ready` tied high.
- `done` asserts in the cycle after the last handshake.
- For an empty list, `done` asserts in cycle 1.
- Reset mid-traversal: immediate return to IDLE, `ll_op_start` and `m_valid` drop asynchronously, no `done` pulse.

## Configuration
- **`SLL_READER_PREFETCH_EN` defined:**
  - On capturing a non-last node, the next read is issued in the same cycle OUT begins (`ll_op_start` stays high with `ll_addr = next`).
  - The returned node is held in a one-entry prefetch buffer until the current beat handshakes.
  - Throughput is 2 cycles/node with `m_ready` high.
  - The prefetch is skipped when `next >= MAX_NODE` or `m_last`.
  - A prefetched fault is reported only after the current beat handshakes.
- **Undefined:** strictly serial operation as above; no buffer logic.

## Test plan
- Empty list, `start` → no `m_valid`; `done` pulses in cycle 1; `count=0`, `err=0`.
- List built by push_back of 0x11, 0x22, 0x33 → beats 0x11, 0x22, 0x33 on addrs 0, 1, 2; `m_last` only on 0x33; `count=3`; `done` one cycle later.
- Delete node 1 then push_front 0x44 into the freed slot (list 0x44 @1, 0x11 @0, 0x33 @2) → beats in that order; the stale tail pointer does not add a fourth beat.
- `m_ready` low for 5 cycles on beat 2 → `m_data`/`m_addr` held stable; no extra `ll_op_start` in the non-prefetch build.
- Force `ll_fault` on the second read → `err=1`, `done` pulses, one beat streamed; `err` is cleared by the next `start`.
- `rst` asserted while in REQ → `ll_op_start` and `busy` drop to 0 immediately; a subsequent `start` traverses correctly.
